hazard_stall_ctrl: RTL and testbench

- Pipeline interlock controller for the 5-stage CPU; the stall/flush counterpart of the forwarding unit.
- The forwarding unit steers data to the EX-stage consumer. This block handles the hazards forwarding cannot cover:
  - load-use (producer load in EX, consumer in ID)
  - taken branches resolved in EX
  - data-memory wait states
- It drives the write enables, flushes and bubble insertion on PC, IF/ID, ID/EX and EX/MEM, and keeps saturating stall/flush counters.

---
 rtl/hazard_stall_ctrl.sv | 163 ++++++++++++++++
 tb/tb_hazard_stall_ctrl.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl.sv
// Pipeline interlock controller: load-use stalls, taken-branch flushes,
// data-memory wait-state freezes, memory timeout flag and saturating counters.
module hazard_stall_ctrl #(
  parameter int unsigned LOAD_LAT    = 1,
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             MemR_EX,
  input  logic [4:0]       EX_rfWeSel,
  input  logic [4:0]       ID_rfReSel1,
  input  logic [4:0]       ID_rfReSel2,
  input  logic             ID_UsesRs,
  input  logic             ID_UsesRt,
  input  logic             Branch_taken_EX,
  input  logic             Mem_busy,
  output logic             PC_Write,
  output logic             IFID_Write,
  output logic             IFID_Flush,
  output logic             IDEX_Write,
  output logic             IDEX_Bubble,
  output logic             EXMEM_Hold,
  output logic             Mem_timeout,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  localparam int unsigned REM_W = 4;
  localparam int unsigned TO_W  = 8;
  localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);
  localparam logic [TO_W-1:0]  TO_LIMIT = TO_W'(MEM_TIMEOUT);

  typedef enum logic [1:0] {RUN, LSTALL, FLUSH} state_t;

  state_t            state_q, state_d;
  logic [REM_W-1:0]  rem_q, rem_d;
  logic [TO_W-1:0]   tcnt_q, tcnt_d;
  logic              lu;
  logic              stall_inc;
  logic              flush_inc;

  // Load-use hazard: load in EX writes a register that ID actually reads
  always_comb begin
    lu = MemR_EX && (EX_rfWeSel != 5'd0) &&
         ((ID_UsesRs && (EX_rfWeSel == ID_rfReSel1)) ||
          (ID_UsesRt && (EX_rfWeSel == ID_rfReSel2)));
  end

  // Next-state and Mealy outputs, priority: reset, mem busy, branch, load-use
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    PC_Write    = 1'b1;
    IFID_Write  = 1'b1;
    IFID_Flush  = 1'b0;
    IDEX_Write  = 1'b1;
    IDEX_Bubble = 1'b0;
    EXMEM_Hold  = 1'b0;

    if (Mem_busy) begin
      PC_Write   = 1'b0;
      IFID_Write = 1'b0;
      IDEX_Write = 1'b0;
      EXMEM_Hold = 1'b1;
    end else begin
      case (state_q)
        RUN: begin
          if (Branch_taken_EX) begin
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            flush_inc   = 1'b1;
            state_d     = FLUSH;
          end else if (lu) begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            stall_inc   = 1'b1;
            if (LOAD_LAT > 1) begin
              state_d = LSTALL;
              rem_d   = REM_INIT;
            end
          end
        end
        LSTALL: begin
          if (Branch_taken_EX) begin
            // consumer is flushed, so the pending stall is dropped
            IFID_Flush  = 1'b1;
            IDEX_Bubble = 1'b1;
            flush_inc   = 1'b1;
            rem_d       = '0;
            state_d     = FLUSH;
          end else begin
            PC_Write    = 1'b0;
            IFID_Write  = 1'b0;
            IDEX_Bubble = 1'b1;
            stall_inc   = 1'b1;
            rem_d       = rem_q - REM_W'(1);
            if (rem_q == REM_W'(1)) state_d = RUN;
          end
        end
        FLUSH: begin
          // EX holds a bubble: branch and load-use inputs are meaningless here
          IDEX_Bubble = 1'b1;
          state_d     = RUN;
        end
        default: state_d = RUN;
      endcase
    end

    if (Reset) begin
      PC_Write    = 1'b0;
      IFID_Write  = 1'b0;
      IFID_Flush  = 1'b1;
      IDEX_Write  = 1'b1;
      IDEX_Bubble = 1'b1;
      EXMEM_Hold  = 1'b0;
    end
  end

  // Consecutive Mem_busy counter, saturating at the timeout limit
  always_comb begin
    tcnt_d = tcnt_q;
    if (!Mem_busy) tcnt_d = '0;
    else if (tcnt_q != TO_LIMIT) tcnt_d = tcnt_q + TO_W'(1);
  end

  // FSM state and remaining stall cycles
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= RUN;
      rem_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // Timeout counter and sticky timeout flag
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      tcnt_q      <= '0;
      Mem_timeout <= 1'b0;
    end else begin
      tcnt_q <= tcnt_d;
      if (tcnt_d == TO_LIMIT) Mem_timeout <= 1'b1;
    end
  end

  // Saturating performance counters
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCnt <= '0;
      FlushCnt <= '0;
    end else begin
      if (stall_inc && (StallCnt != '1)) StallCnt <= StallCnt + CNT_W'(1);
      if (flush_inc && (FlushCnt != '1)) FlushCnt <= FlushCnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed bench for hazard_stall_ctrl: three instances share stimulus
// (LOAD_LAT=1, LOAD_LAT=3, and LOAD_LAT=1 with 4-bit counters).
module tb_hazard_stall_ctrl;

  // Output vector order: {PC_Write, IFID_Write, IFID_Flush, IDEX_Write, IDEX_Bubble, EXMEM_Hold}
  localparam logic [5:0] O_RUN   = 6'b110100;
  localparam logic [5:0] O_STALL = 6'b000110;
  localparam logic [5:0] O_BR    = 6'b111110;
  localparam logic [5:0] O_FLUSH = 6'b110110;
  localparam logic [5:0] O_FRZ   = 6'b000001;
  localparam logic [5:0] O_RST   = 6'b001110;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       MemR_EX;
  logic [4:0] EX_rfWeSel, ID_rfReSel1, ID_rfReSel2;
  logic       ID_UsesRs, ID_UsesRt, Branch_taken_EX, Mem_busy;

  logic [5:0]  oa, ob, oc;
  logic        toa, tob, toc;
  logic [15:0] sa, fa, sb, fb;
  logic [3:0]  sc, fc;

  int checks = 0;
  int failures = 0;

  always #5 Clk = ~Clk;

  hazard_stall_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(64), .CNT_W(16)) u_a (
    .Clk(Clk), .Reset(Reset), .MemR_EX(MemR_EX), .EX_rfWeSel(EX_rfWeSel),
    .ID_rfReSel1(ID_rfReSel1), .ID_rfReSel2(ID_rfReSel2),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .Branch_taken_EX(Branch_taken_EX), .Mem_busy(Mem_busy),
    .PC_Write(oa[5]), .IFID_Write(oa[4]), .IFID_Flush(oa[3]),
    .IDEX_Write(oa[2]), .IDEX_Bubble(oa[1]), .EXMEM_Hold(oa[0]),
    .Mem_timeout(toa), .StallCnt(sa), .FlushCnt(fa));

  hazard_stall_ctrl #(.LOAD_LAT(3), .MEM_TIMEOUT(64), .CNT_W(16)) u_b (
    .Clk(Clk), .Reset(Reset), .MemR_EX(MemR_EX), .EX_rfWeSel(EX_rfWeSel),
    .ID_rfReSel1(ID_rfReSel1), .ID_rfReSel2(ID_rfReSel2),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .Branch_taken_EX(Branch_taken_EX), .Mem_busy(Mem_busy),
    .PC_Write(ob[5]), .IFID_Write(ob[4]), .IFID_Flush(ob[3]),
    .IDEX_Write(ob[2]), .IDEX_Bubble(ob[1]), .EXMEM_Hold(ob[0]),
    .Mem_timeout(tob), .StallCnt(sb), .FlushCnt(fb));

  hazard_stall_ctrl #(.LOAD_LAT(1), .MEM_TIMEOUT(64), .CNT_W(4)) u_c (
    .Clk(Clk), .Reset(Reset), .MemR_EX(MemR_EX), .EX_rfWeSel(EX_rfWeSel),
    .ID_rfReSel1(ID_rfReSel1), .ID_rfReSel2(ID_rfReSel2),
    .ID_UsesRs(ID_UsesRs), .ID_UsesRt(ID_UsesRt),
    .Branch_taken_EX(Branch_taken_EX), .Mem_busy(Mem_busy),
    .PC_Write(oc[5]), .IFID_Write(oc[4]), .IFID_Flush(oc[3]),
    .IDEX_Write(oc[2]), .IDEX_Bubble(oc[1]), .EXMEM_Hold(oc[0]),
    .Mem_timeout(toc), .StallCnt(sc), .FlushCnt(fc));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle();
    MemR_EX = 1'b0; EX_rfWeSel = 5'd0; ID_rfReSel1 = 5'd0; ID_rfReSel2 = 5'd0;
    ID_UsesRs = 1'b0; ID_UsesRt = 1'b0; Branch_taken_EX = 1'b0; Mem_busy = 1'b0;
  endtask

  task automatic lu_rs();
    idle();
    MemR_EX = 1'b1; EX_rfWeSel = 5'd5; ID_rfReSel1 = 5'd5; ID_UsesRs = 1'b1;
  endtask

  task automatic lu_rt();
    idle();
    MemR_EX = 1'b1; EX_rfWeSel = 5'd5; ID_rfReSel2 = 5'd5; ID_UsesRt = 1'b1;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    #2;
    chk("reset_outs", 32'(oa), 32'(O_RST));
    chk("reset_stallcnt", 32'(sa), 32'd0);
    chk("reset_timeout", 32'(toa), 32'd0);
    tick(); tick();
    Reset = 1'b0;
    #1;
    chk("run_outs_a", 32'(oa), 32'(O_RUN));
    chk("run_outs_b", 32'(ob), 32'(O_RUN));

    // Load-use through rs: one stall for LOAD_LAT=1, three for LOAD_LAT=3
    lu_rs(); #1;
    chk("lu1_stall_a", 32'(oa), 32'(O_STALL));
    chk("lu1_stall_b", 32'(ob), 32'(O_STALL));
    tick(); idle(); #1;
    chk("lu1_after_a", 32'(oa), 32'(O_RUN));
    chk("lu1_cnt_a", 32'(sa), 32'd1);
    chk("lu1_cnt_c", 32'(sc), 32'd1);
    chk("lu3_c2_b", 32'(ob), 32'(O_STALL));
    tick();
    chk("lu3_c3_b", 32'(ob), 32'(O_STALL));
    tick();
    chk("lu3_end_b", 32'(ob), 32'(O_RUN));
    chk("lu3_cnt_b", 32'(sb), 32'd3);

    // Load-use through rt, LU dropped after first cycle
    lu_rt(); #1;
    chk("rt_stall_b", 32'(ob), 32'(O_STALL));
    tick(); idle(); #1;
    chk("rt_c2_b", 32'(ob), 32'(O_STALL));
    tick();
    chk("rt_c3_b", 32'(ob), 32'(O_STALL));
    tick();
    chk("rt_end_b", 32'(ob), 32'(O_RUN));
    chk("rt_cnt_b", 32'(sb), 32'd6);
    chk("rt_cnt_a", 32'(sa), 32'd2);

    // No-hazard cases: r0 destination, unused rt, non-load
    idle(); MemR_EX = 1'b1; ID_UsesRs = 1'b1; ID_UsesRt = 1'b1; #1;
    chk("r0_nostall_a", 32'(oa), 32'(O_RUN));
    chk("r0_nostall_b", 32'(ob), 32'(O_RUN));
    lu_rt(); ID_UsesRt = 1'b0; #1;
    chk("unused_rt_nostall", 32'(ob), 32'(O_RUN));
    lu_rs(); MemR_EX = 1'b0; #1;
    chk("nonload_nostall", 32'(oa), 32'(O_RUN));
    idle(); tick();

    // Taken branch while LSTALL has two cycles left
    lu_rt(); #1;
    tick(); idle(); Branch_taken_EX = 1'b1; #1;
    chk("br_lstall_b", 32'(ob), 32'(O_BR));
    chk("br_run_a", 32'(oa), 32'(O_BR));
    tick(); #1;
    chk("br_flushcnt_b", 32'(fb), 32'd1);
    chk("br_stallcnt_b", 32'(sb), 32'd7);
    chk("flush_outs_b", 32'(ob), 32'(O_FLUSH));
    tick(); Branch_taken_EX = 1'b0; #1;
    chk("flush_ignore_br", 32'(fb), 32'd1);
    chk("after_flush_b", 32'(ob), 32'(O_RUN));
    chk("after_flush_sb", 32'(sb), 32'd7);

    // Memory freeze in the middle of LSTALL
    lu_rs(); #1;
    tick(); idle(); Mem_busy = 1'b1; #1;
    for (int i = 0; i < 5; i++) begin
      chk("freeze_b", 32'(ob), 32'(O_FRZ));
      tick();
    end
    chk("freeze_sb", 32'(sb), 32'd8);
    Mem_busy = 1'b0; #1;
    chk("resume_c2_b", 32'(ob), 32'(O_STALL));
    tick();
    chk("resume_c3_b", 32'(ob), 32'(O_STALL));
    tick();
    chk("resume_end_b", 32'(ob), 32'(O_RUN));
    chk("resume_sb", 32'(sb), 32'd10);
    chk("short_busy_no_to", 32'(toa), 32'd0);

    // Memory timeout after 64 consecutive busy cycles
    Mem_busy = 1'b1;
    for (int i = 0; i < 63; i++) tick();
    chk("to_63", 32'(toa), 32'd0);
    tick();
    chk("to_64", 32'(toa), 32'd1);
    Mem_busy = 1'b0;
    tick();
    chk("to_sticky", 32'(toa), 32'd1);

    // Asynchronous reset in the middle of LSTALL
    lu_rs(); #1;
    tick(); idle(); #1;
    chk("pre_rst_b", 32'(ob), 32'(O_STALL));
    Reset = 1'b1; #1;
    chk("async_rst_outs", 32'(ob), 32'(O_RST));
    chk("async_rst_sb", 32'(sb), 32'd0);
    chk("async_rst_fb", 32'(fb), 32'd0);
    chk("async_rst_to", 32'(toa), 32'd0);
    tick();
    Reset = 1'b0; #1;
    chk("post_rst_b", 32'(ob), 32'(O_RUN));
    tick();
    chk("no_resume_b", 32'(ob), 32'(O_RUN));
    chk("no_resume_sb", 32'(sb), 32'd0);

    // StallCnt saturation on the 4-bit instance
    lu_rs();
    for (int i = 0; i < 14; i++) tick();
    chk("sat_14", 32'(sc), 32'd14);
    for (int i = 0; i < 6; i++) tick();
    chk("sat_hold", 32'(sc), 32'd15);
    chk("nosat_a", 32'(sa), 32'd20);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
